// File: rtl/mac_rx_pkg.sv
// Shared types and helpers for the 10G MAC receive packer.
// Holds width helpers, default sizes, assembler states, FIFO entry layout.
package mac_rx_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int in_ew(input int ib);
    return (clog2(ib) > 1) ? clog2(ib) : 1;
  endfunction

  localparam int IN_BYTES_DEF = 4;
  localparam int RATIO_DEF    = 2;
  localparam int OUT_BYTES    = IN_BYTES_DEF * RATIO_DEF;
  localparam int IN_EW        = in_ew(IN_BYTES_DEF);
  localparam int OUT_EW       = clog2(OUT_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PKT  = 2'd1,
    ST_DROP = 2'd2
  } asm_st_e;

  // Entry layout, LSB first: data, empty, eop, sop, err.
  function automatic int off_empty(input int ob);
    return ob * 8;
  endfunction

  function automatic int off_eop(input int ob);
    return ob * 8 + clog2(ob);
  endfunction

  function automatic int off_sop(input int ob);
    return off_eop(ob) + 1;
  endfunction

  function automatic int off_err(input int ob);
    return off_eop(ob) + 2;
  endfunction

  function automatic int ent_w(input int ob);
    return off_eop(ob) + 3;
  endfunction

endpackage

// File: rtl/mac_rx_pkt_packer_if.sv
// Narrow MAC beat input and wide packed-word output with valid/ready.
// master: beat source + word consumer; slave: the packer.
interface mac_rx_pkt_packer_if
  import mac_rx_pkg::*;
#(
  parameter int IN_BYTES = 4,
  parameter int RATIO    = 2
);
  localparam int OB  = IN_BYTES * RATIO;
  localparam int IEW = in_ew(IN_BYTES);
  localparam int OEW = clog2(OB);

  logic [IN_BYTES*8-1:0] in_data;
  logic [IEW-1:0]        in_empty;
  logic                  in_vld;
  logic                  in_sop;
  logic                  in_eop;
  logic [OB*8-1:0]       out_data;
  logic [OEW-1:0]        out_empty;
  logic                  out_sop;
  logic                  out_eop;
  logic                  out_err;
  logic                  out_vld;
  logic                  out_ready;

  modport master (
    output in_data, in_empty, in_vld, in_sop, in_eop,
    output out_ready,
    input  out_data, out_empty, out_sop, out_eop,
    input  out_err, out_vld
  );

  modport slave (
    input  in_data, in_empty, in_vld, in_sop, in_eop,
    input  out_ready,
    output out_data, out_empty, out_sop, out_eop,
    output out_err, out_vld
  );

endinterface

// File: rtl/mac_rx_pkt_packer_sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO, power-of-2 depth.
// Ports: clk/rst_n, wr_en_i/wr_data_i, rd_en_i/rd_data_o, full_o, empty_o.
module sync_fwft_fifo
  import mac_rx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wp_q;
  logic [AW:0]      rp_q;
  logic             do_rd;
  logic             do_wr;

  assign empty_o = (wp_q == rp_q);
  assign full_o  = (wp_q[AW] != rp_q[AW]) &&
                   (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign do_rd   = rd_en_i && !empty_o;
  // A push into a full FIFO is legal when the head leaves this cycle.
  assign do_wr   = wr_en_i && (!full_o || do_rd);
  assign rd_data_o = mem_q[rp_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_wr) begin
        mem_q[wp_q[AW-1:0]] <= wr_data_i;
        wp_q <= wp_q + (AW+1)'(1);
      end
      if (do_rd) rp_q <= rp_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/mac_rx_pkt_packer.sv
// Packs RATIO MAC beats into one wide word, drops/marks packets on overflow.
// Ports: clk_322, rst_n_322, bus (slave), clr_stats, drop_pkt_cnt, ovf_sticky.
module mac_rx_pkt_packer
  import mac_rx_pkg::*;
#(
  parameter int IN_BYTES   = 4,
  parameter int RATIO      = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic               clk_322,
  input  logic               rst_n_322,
  mac_rx_pkt_packer_if.slave bus,
  input  logic               clr_stats,
  output logic [CNT_W-1:0]   drop_pkt_cnt,
  output logic               ovf_sticky
);
  localparam int OB  = IN_BYTES * RATIO;
  localparam int BW  = IN_BYTES * 8;
  localparam int DW  = OB * 8;
  localparam int OEW = clog2(OB);
  localparam int LW  = clog2(RATIO);
  localparam int FW  = ent_w(OB);

  asm_st_e          st_q, st_d;
  logic [LW-1:0]    lane_q, lane_d, lane_c;
  logic [DW-1:0]    acc_q, acc_d, acc_c, acc_n;
  logic             sop_q, sop_d;
  logic             wr_q, wr_d, wr_c;
  logic             abt_q, abt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W:0]   sum;
  logic [1:0]       inc;
  logic             take, done, blocked;
  logic             old_abt, abt_set, ovf_set;
  logic             push, pop, full, empty, full_eff;
  logic [FW-1:0]    push_w, rd_w;
  logic [OEW-1:0]   ine, emp;

  assign pop      = !empty && bus.out_ready;
  assign full_eff = full && !pop;

  // A sop beat restarts assembly regardless of leftover lanes.
  assign lane_c = bus.in_sop ? '0 : lane_q;
  assign acc_c  = bus.in_sop ? '0 : acc_q;
  assign wr_c   = bus.in_sop ? 1'b0 : wr_q;
  assign acc_n  = acc_c |
    (DW'(bus.in_data) << ((RATIO - 1 - int'(lane_c)) * BW));
  assign done   = (lane_c == LW'(RATIO - 1)) || bus.in_eop;
  assign ine    = (IN_BYTES > 1) ? OEW'(bus.in_empty) : '0;
  assign emp    = OEW'((RATIO - 1 - int'(lane_c)) * IN_BYTES) + ine;

  always_comb begin
    st_d    = st_q;
    lane_d  = lane_q;
    acc_d   = acc_q;
    sop_d   = sop_q;
    wr_d    = wr_q;
    inc     = '0;
    take    = 1'b0;
    blocked = 1'b0;
    old_abt = 1'b0;
    abt_set = 1'b0;
    ovf_set = 1'b0;
    push    = 1'b0;
    push_w  = '0;

    if (bus.in_vld) begin
      if (bus.in_sop) begin
        if (st_q == ST_PKT) begin
          inc     = inc + 2'd1;
          old_abt = wr_q;
        end
        lane_d = '0;
        acc_d  = '0;
        sop_d  = 1'b1;
        wr_d   = 1'b0;
        // Pending abort: the new packet is discarded whole.
        if (abt_q) begin
          inc  = inc + 2'd1;
          st_d = bus.in_eop ? ST_IDLE : ST_DROP;
        end else begin
          take = 1'b1;
        end
      end else if (st_q == ST_PKT) begin
        take = 1'b1;
      end else if (st_q == ST_DROP && bus.in_eop) begin
        st_d = ST_IDLE;
      end
    end

    if (take) begin
      if (done) begin
        acc_d  = '0;
        lane_d = '0;
        // The abort word owns the write port until it is out.
        blocked = full_eff || abt_q || old_abt;
        if (!blocked) begin
          push   = 1'b1;
          push_w = {1'b0, sop_q || bus.in_sop, bus.in_eop,
                    bus.in_eop ? emp : '0, acc_n};
          sop_d  = 1'b0;
          wr_d   = 1'b1;
          st_d   = bus.in_eop ? ST_IDLE : ST_PKT;
        end else begin
          ovf_set = full_eff;
          inc     = inc + 2'd1;
          st_d    = bus.in_eop ? ST_IDLE : ST_DROP;
        end
      end else begin
        acc_d  = acc_n;
        lane_d = lane_c + LW'(1);
        st_d   = ST_PKT;
      end
    end

    abt_set = old_abt || (take && done && blocked && wr_c);
    abt_d   = abt_q || abt_set;
    if (abt_d && !full_eff) begin
      push   = 1'b1;
      push_w = {1'b1, 1'b0, 1'b1, OEW'(OB - 1), DW'(0)};
      abt_d  = 1'b0;
    end

    sum = {1'b0, cnt_q} + (CNT_W+1)'(inc);
    if (clr_stats) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
      ovf_d = ovf_q || ovf_set;
    end
  end

  always_ff @(posedge clk_322 or negedge rst_n_322) begin
    if (!rst_n_322) begin
      st_q   <= ST_IDLE;
      lane_q <= '0;
      acc_q  <= '0;
      sop_q  <= 1'b0;
      wr_q   <= 1'b0;
      abt_q  <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      lane_q <= lane_d;
      acc_q  <= acc_d;
      sop_q  <= sop_d;
      wr_q   <= wr_d;
      abt_q  <= abt_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  sync_fwft_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_322),
    .rst_n     (rst_n_322),
    .wr_en_i   (push),
    .wr_data_i (push_w),
    .rd_en_i   (bus.out_ready),
    .rd_data_o (rd_w),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign bus.out_data  = rd_w[DW-1:0];
  assign bus.out_empty = rd_w[off_empty(OB) +: OEW];
  assign bus.out_eop   = rd_w[off_eop(OB)];
  assign bus.out_sop   = rd_w[off_sop(OB)];
  assign bus.out_err   = rd_w[off_err(OB)];
  assign bus.out_vld   = !empty;
  assign drop_pkt_cnt  = cnt_q;
  assign ovf_sticky    = ovf_q;

endmodule

// File: tb/tb_mac_rx_pkt_packer.sv
// Bench for mac_rx_pkt_packer: RATIO=2 and RATIO=4 instances, shared stimulus.
// Byte-level reference model feeds expected-word queues; monitors compare.
module tb_mac_rx_pkt_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic [1:0]  in_empty = '0;
  logic        in_vld = 1'b0;
  logic        in_sop = 1'b0;
  logic        in_eop = 1'b0;
  logic        out_ready = 1'b1;
  logic        clr_stats = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  function automatic void chk(input bit ok, input string nm,
                              input string msg);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s %s", nm, msg);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int R    = (g == 0) ? 2 : 4;
    localparam int OB   = 4 * R;
    localparam int CW   = (g == 0) ? 16 : 3;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
      logic [OB*8-1:0] data;
      int              empty;
      bit              sop;
      bit              eop;
      bit              err;
    } wd_t;

    wd_t           q[$];
    byte unsigned  bq[$];
    bit            in_pkt, first, wrote, ab_pend, m_ovf;
    int            m_cnt;
    logic [CW-1:0] cnt;
    logic          ovf;

    mac_rx_pkt_packer_if #(.IN_BYTES(4), .RATIO(R)) bus ();

    assign bus.in_data   = in_data;
    assign bus.in_empty  = in_empty;
    assign bus.in_vld    = in_vld;
    assign bus.in_sop    = in_sop;
    assign bus.in_eop    = in_eop;
    assign bus.out_ready = out_ready;

    mac_rx_pkt_packer #(
      .IN_BYTES   (4),
      .RATIO      (R),
      .FIFO_DEPTH (4),
      .CNT_W      (CW)
    ) dut (
      .clk_322      (clk),
      .rst_n_322    (rst_n),
      .bus          (bus),
      .clr_stats    (clr_stats),
      .drop_pkt_cnt (cnt),
      .ovf_sticky   (ovf)
    );

    always @(posedge clk or negedge rst_n) begin : model
      int  n;
      bit  take, need_ab, ovf_hit;
      wd_t w;
      if (!rst_n) begin
        q.delete();
        bq.delete();
        in_pkt  = 0;
        first   = 0;
        wrote   = 0;
        ab_pend = 0;
        m_ovf   = 0;
        m_cnt   = 0;
      end else begin
        if (q.size() > 0 && out_ready) w = q.pop_front();
        n = 0;
        take = 0;
        need_ab = 0;
        ovf_hit = 0;
        if (in_vld) begin
          if (in_sop) begin
            if (in_pkt) begin
              n++;
              if (wrote) need_ab = 1;
            end
            bq.delete();
            first = 1;
            wrote = 0;
            in_pkt = 0;
            if (ab_pend) n++;
            else begin
              in_pkt = 1;
              take = 1;
            end
          end else if (in_pkt) begin
            take = 1;
          end
        end
        if (take) begin
          for (int b = 0; b < 4; b++)
            bq.push_back(in_data[31-8*b -: 8]);
          if (bq.size() == OB || in_eop) begin
            if (q.size() < 4 && !ab_pend && !need_ab) begin
              w.data = '0;
              for (int i = 0; i < bq.size(); i++)
                w.data[OB*8-1-8*i -: 8] = bq[i];
              w.empty = in_eop ? OB - bq.size() + int'(in_empty) : 0;
              w.sop = first;
              w.eop = in_eop;
              w.err = 0;
              q.push_back(w);
              first = 0;
              wrote = 1;
              in_pkt = !in_eop;
            end else begin
              if (q.size() >= 4) ovf_hit = 1;
              n++;
              if (wrote) need_ab = 1;
              in_pkt = 0;
            end
            bq.delete();
          end
        end
        if (ab_pend || need_ab) begin
          if (q.size() < 4) begin
            w.data = '0;
            w.empty = OB - 1;
            w.sop = 0;
            w.eop = 1;
            w.err = 1;
            q.push_back(w);
            ab_pend = 0;
          end else begin
            ab_pend = 1;
          end
        end
        if (clr_stats) begin
          m_cnt = 0;
          m_ovf = 0;
        end else begin
          m_cnt = (m_cnt + n > CMAX) ? CMAX : m_cnt + n;
          if (ovf_hit) m_ovf = 1;
        end
      end
    end

    always @(negedge clk) begin : monitor
      wd_t e;
      if (!rst_n) begin
        chk(!bus.out_vld && bus.out_data == '0 && cnt == '0 && !ovf,
            $sformatf("cfg%0d_reset", g),
            $sformatf("vld=%0b data=%h cnt=%0d ovf=%0b required all 0",
                      bus.out_vld, bus.out_data, cnt, ovf));
      end else begin
        chk(bus.out_vld == (q.size() != 0), $sformatf("cfg%0d_vld", g),
            $sformatf("got %0b required %0b", bus.out_vld, q.size() != 0));
        if (bus.out_vld && q.size() != 0) begin
          e = q[0];
          chk(bus.out_data == e.data && int'(bus.out_empty) == e.empty &&
              bus.out_sop == e.sop && bus.out_eop == e.eop &&
              bus.out_err == e.err, $sformatf("cfg%0d_word", g),
              $sformatf("got %h e%0d s%0b e%0b x%0b required %h e%0d s%0b e%0b x%0b",
                        bus.out_data, bus.out_empty, bus.out_sop,
                        bus.out_eop, bus.out_err, e.data, e.empty,
                        e.sop, e.eop, e.err));
        end
        chk(int'(cnt) == m_cnt, $sformatf("cfg%0d_drop_cnt", g),
            $sformatf("got %0d required %0d", cnt, m_cnt));
        chk(ovf == m_ovf, $sformatf("cfg%0d_ovf", g),
            $sformatf("got %0b required %0b", ovf, m_ovf));
      end
    end
  end

  task automatic drive(input bit v, input bit s, input bit e,
                       input logic [1:0] emp);
    @(negedge clk);
    in_vld   = v;
    in_sop   = s;
    in_eop   = e;
    in_data  = $urandom;
    in_empty = emp;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic pkt(input int nb, input logic [1:0] emp);
    for (int i = 0; i < nb; i++)
      drive(1'b1, i == 0, i == nb - 1,
            (i == nb - 1) ? emp : 2'($urandom));
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #2;
    rst_n  = 1'b0;
    in_vld = 1'b0;
    repeat (n) @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    bit slow;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;

    pkt(4, 2'd0);
    idle(4);
    pkt(4, 2'd3);
    pkt(2, 2'd3);
    pkt(1, 2'd2);
    idle(4);
    pkt(6, 2'd1);
    idle(4);

    out_ready = 1'b0;
    pkt(12, 2'd0);
    idle(3);
    pkt(2, 2'd0);
    idle(2);
    @(negedge clk);
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    out_ready = 1'b1;
    idle(12);

    drive(1'b1, 1'b1, 1'b0, 2'd0);
    drive(1'b1, 1'b0, 1'b0, 2'd0);
    drive(1'b1, 1'b0, 1'b0, 2'd0);
    pkt(3, 2'd1);
    idle(8);

    out_ready = 1'b0;
    pkt(3, 2'd0);
    do_reset(2);
    out_ready = 1'b1;
    pkt(2, 2'd0);
    idle(6);

    for (int c = 0; c < 4000; c++) begin
      slow = ((c / 300) % 3) == 2;
      @(negedge clk);
      out_ready = slow ? ($urandom % 8 == 0) : ($urandom % 4 != 0);
      clr_stats = ($urandom % 400 == 0);
      in_vld    = ($urandom % 5 != 0);
      in_sop    = ($urandom % 7 == 0);
      in_eop    = ($urandom % 5 == 0);
      in_data   = $urandom;
      in_empty  = 2'($urandom);
    end

    @(negedge clk);
    in_vld    = 1'b0;
    clr_stats = 1'b0;
    out_ready = 1'b1;
    idle(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
